// File: rtl/single_min_max_scan.sv
// Streaming min/max scan over IEEE-754 single-precision elements using one shared comparator.
// Optional abort input is enabled by defining SINGLE_MINMAX_ABORT_EN.

module single_less_than (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);

  // Sign-magnitude ordering: negatives reverse magnitude order, and -0.0 sorts below +0.0.
  always_comb begin
    lt = 1'b0;
    case ({a[31], b[31]})
      2'b00:   lt = (a[30:0] < b[30:0]);
      2'b01:   lt = 1'b0;
      2'b10:   lt = 1'b1;
      2'b11:   lt = (a[30:0] > b[30:0]);
      default: lt = 1'b0;
    endcase
  end

endmodule

module single_min_max_scan #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1),
  parameter int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef SINGLE_MINMAX_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             err_empty,
  output logic [31:0]      min_val,
  output logic [31:0]      max_val,
  output logic [IDX_W-1:0] min_idx,
  output logic [IDX_W-1:0] max_idx
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT_IN = 3'd1;
  localparam logic [2:0] CMP_MIN = 3'd2;
  localparam logic [2:0] CMP_MAX = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len_reg;
  logic [31:0]      hold_reg;
  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;
  logic             cmp_lt;
  logic             abort_hit;

`ifdef SINGLE_MINMAX_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign in_ready = (state == WAIT_IN);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  // Operand steering for the single shared comparator.
  always_comb begin
    cmp_a = 32'h0000_0000;
    cmp_b = 32'h0000_0000;
    case (state)
      CMP_MIN: begin
        cmp_a = hold_reg;
        cmp_b = min_val;
      end
      CMP_MAX: begin
        cmp_a = max_val;
        cmp_b = hold_reg;
      end
      default: begin
        cmp_a = 32'h0000_0000;
        cmp_b = 32'h0000_0000;
      end
    endcase
  end

  single_less_than u_lt (
    .a  (cmp_a),
    .b  (cmp_b),
    .lt (cmp_lt)
  );

  // Scan control and result registers; results persist until the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      len_reg   <= '0;
      hold_reg  <= 32'h0000_0000;
      min_val   <= 32'h0000_0000;
      max_val   <= 32'h0000_0000;
      min_idx   <= '0;
      max_idx   <= '0;
      err_empty <= 1'b0;
    end else if (abort_hit) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            if (len == '0) begin
              err_empty <= 1'b1;
              state     <= DONE;
            end else begin
              err_empty <= 1'b0;
              len_reg   <= (len > MAX_LEN_C) ? MAX_LEN_C : len;
              state     <= WAIT_IN;
            end
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            hold_reg <= in_data;
            count    <= count + CNT_W'(1);
            if (count == '0) begin
              min_val <= in_data;
              max_val <= in_data;
              min_idx <= '0;
              max_idx <= '0;
              state   <= (len_reg == CNT_W'(1)) ? DONE : WAIT_IN;
            end else begin
              state <= CMP_MIN;
            end
          end
        end
        CMP_MIN: begin
          if (cmp_lt) begin
            min_val <= hold_reg;
            min_idx <= IDX_W'(count - CNT_W'(1));
          end
          state <= CMP_MAX;
        end
        CMP_MAX: begin
          if (cmp_lt) begin
            max_val <= hold_reg;
            max_idx <= IDX_W'(count - CNT_W'(1));
          end
          state <= (count == len_reg) ? DONE : WAIT_IN;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_single_min_max_scan.sv
// Self-checking bench for single_min_max_scan: directed cases plus randomized scans
// against an ordering-key reference model.

module tb_single_min_max_scan;

  localparam int MAXL  = 8;
  localparam int CNT_W = 4;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = 32'h0;
  logic             in_ready, busy, done, err_empty;
  logic [31:0]      min_val, max_val;
  logic [IDX_W-1:0] min_idx, max_idx;
`ifdef SINGLE_MINMAX_ABORT_EN
  logic             abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] elems [16];
  logic [31:0] specials [6];

  single_min_max_scan #(.MAX_LEN(MAXL)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SINGLE_MINMAX_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .err_empty (err_empty),
    .min_val   (min_val),
    .max_val   (max_val),
    .min_idx   (min_idx),
    .max_idx   (max_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Map a float bit pattern onto an unsigned key whose order is the required float order.
  function automatic logic [32:0] key(input logic [31:0] x);
    return x[31] ? {1'b0, ~x} : {1'b0, x | 32'h8000_0000};
  endfunction

  task automatic model(input int n, output logic [31:0] mn, output logic [31:0] mx,
                       output int mni, output int mxi);
    mn = elems[0]; mx = elems[0]; mni = 0; mxi = 0;
    for (int i = 1; i < n; i++) begin
      if (key(elems[i]) < key(mn)) begin mn = elems[i]; mni = i; end
      if (key(mx) < key(elems[i])) begin mx = elems[i]; mxi = i; end
    end
  endtask

  task automatic run_scan(input int len_in, input bit gaps, input bit poke,
                          output int lat, output bit saw_ready);
    int eff;
    int idx;
    eff = (len_in > MAXL) ? MAXL : len_in;
    @(negedge clk);
    start = 1'b1; len = len_in[CNT_W-1:0]; in_valid = 1'b0;
    idx = 0; lat = -1; saw_ready = 1'b0;
    for (int cyc = 1; cyc <= 300 && lat < 0; cyc++) begin
      @(negedge clk);
      if (poke) begin
        start = ($urandom_range(0, 2) == 0);
        len   = '0;
      end else begin
        start = 1'b0;
      end
      if (in_ready) saw_ready = 1'b1;
      if (done) begin
        lat = cyc; start = 1'b0; in_valid = 1'b0;
      end else begin
        in_valid = (idx < eff) && (!gaps || $urandom_range(0, 1) == 1);
        in_data  = (idx < eff) ? elems[idx] : $urandom;
        if (in_valid && in_ready) idx++;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    if (lat < 0) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_scan(input string tag, input int len_in, input bit gaps, input bit poke);
    int lat, mni, mxi, eff;
    bit saw;
    logic [31:0] mn, mx;
    eff = (len_in > MAXL) ? MAXL : len_in;
    model(eff, mn, mx, mni, mxi);
    run_scan(len_in, gaps, poke, lat, saw);
    chk({tag, "_min"}, min_val, mn);
    chk({tag, "_max"}, max_val, mx);
    chk({tag, "_min_idx"}, 32'(min_idx), 32'(mni));
    chk({tag, "_max_idx"}, 32'(max_idx), 32'(mxi));
    chk({tag, "_err_empty"}, 32'(err_empty), 32'd0);
    if (!gaps) chk({tag, "_latency"}, 32'(lat), 32'(2 + 3 * (eff - 1)));
  endtask

  initial begin
    int lat, dcount, n;
    bit saw;
    specials[0] = 32'h0000_0000; specials[1] = 32'h8000_0000;
    specials[2] = 32'h7F80_0000; specials[3] = 32'hFF80_0000;
    specials[4] = 32'h3F80_0000; specials[5] = 32'hBF80_0000;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_min", min_val, 32'd0);
    chk("rst_max", max_val, 32'd0);
    reset = 1'b0;

    elems[0] = 32'h3F80_0000; elems[1] = 32'hC000_0000;
    elems[2] = 32'h4060_0000; elems[3] = 32'h3F00_0000;
    run_scan(4, 1'b0, 1'b0, lat, saw);
    chk("basic_min", min_val, 32'hC000_0000);
    chk("basic_min_idx", 32'(min_idx), 32'd1);
    chk("basic_max", max_val, 32'h4060_0000);
    chk("basic_max_idx", 32'(max_idx), 32'd2);
    chk("basic_err", 32'(err_empty), 32'd0);
    chk("basic_latency", 32'(lat), 32'd11);
    @(negedge clk);
    chk("basic_done_single", 32'(done), 32'd0);

    run_scan(0, 1'b0, 1'b0, lat, saw);
    chk("empty_latency", 32'(lat), 32'd1);
    chk("empty_err", 32'(err_empty), 32'd1);
    chk("empty_no_ready", 32'(saw), 32'd0);
    chk("empty_hold_min", min_val, 32'hC000_0000);
    repeat (3) @(negedge clk);
    chk("empty_err_held", 32'(err_empty), 32'd1);

    elems[0] = 32'h3F80_0000; elems[1] = 32'h3F80_0000; elems[2] = 32'h3F80_0000;
    run_scan(3, 1'b0, 1'b0, lat, saw);
    chk("tie_min_idx", 32'(min_idx), 32'd0);
    chk("tie_max_idx", 32'(max_idx), 32'd0);
    chk("tie_err_cleared", 32'(err_empty), 32'd0);

    elems[0] = 32'h0000_0000; elems[1] = 32'h8000_0000;
    run_scan(2, 1'b0, 1'b0, lat, saw);
    chk("zero_min", min_val, 32'h8000_0000);
    chk("zero_min_idx", 32'(min_idx), 32'd1);
    chk("zero_max", max_val, 32'h0000_0000);
    chk("zero_max_idx", 32'(max_idx), 32'd0);

    for (int i = 0; i < 16; i++) elems[i] = $urandom;
    check_scan("clamp", 15, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      n = $urandom_range(1, MAXL);
      for (int i = 0; i < MAXL; i++) begin
        case ($urandom_range(0, 2))
          0:       elems[i] = specials[$urandom_range(0, 5)];
          1:       elems[i] = elems[$urandom_range(0, 1)];
          default: elems[i] = $urandom;
        endcase
      end
      check_scan("rand", n, t[0], t[1]);
    end

    // Reset in CMP_MIN of a len=4 scan.
    @(negedge clk);
    start = 1'b1; len = 4'd4; in_valid = 1'b1; in_data = 32'h3F80_0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_data = 32'hC000_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_min", min_val, 32'd0);
    chk("mid_rst_max", max_val, 32'd0);
    chk("mid_rst_idx", 32'({min_idx, max_idx}), 32'd0);
    chk("mid_rst_flags", 32'({done, err_empty, in_ready}), 32'd0);
    dcount = 0;
    repeat (3) begin @(negedge clk); if (done) dcount++; end
    reset = 1'b0;
    repeat (3) begin @(negedge clk); if (done) dcount++; end
    chk("mid_rst_no_done", 32'(dcount), 32'd0);
    elems[0] = 32'h4000_0000;
    run_scan(1, 1'b0, 1'b0, lat, saw);
    chk("post_rst_min", min_val, 32'h4000_0000);
    chk("post_rst_max", max_val, 32'h4000_0000);
    chk("post_rst_latency", 32'(lat), 32'd2);

`ifdef SINGLE_MINMAX_ABORT_EN
    @(negedge clk);
    start = 1'b1; len = 4'd4; in_valid = 1'b1; in_data = 32'h3F80_0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    in_data = 32'hC000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1; len = 4'd0;
    repeat (2) @(negedge clk);
    chk("abort_busy_before", 32'(in_ready), 32'd1);
    chk("abort_start_ignored", 32'(err_empty), 32'd0);
    abort = 1'b1; in_valid = 1'b1; in_data = 32'hFF80_0000; start = 1'b0;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_min", min_val, 32'hC000_0000);
    chk("abort_max", max_val, 32'h3F80_0000);
    dcount = 0;
    repeat (4) begin if (done) dcount++; @(negedge clk); end
    chk("abort_no_done", 32'(dcount), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_min_max_scan.md
SINGLE_MIN_MAX_SCAN -- requirements
Module: single_min_max_scan

Interface
REQ-001 Parameter: MAX_LEN, default 256, maximum elements per scan.
REQ-002 Parameter: CNT_W, default $clog2(MAX_LEN+1), width of len and count.
REQ-003 Parameter: IDX_W, default $clog2(MAX_LEN), width of index outputs.
REQ-004 Port: clk  in  1  sole clock, rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: start  in  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-007 Port: len  in  CNT_W  element count, sampled with start.
REQ-008 Port: in_valid  in  1  in_data valid.
REQ-009 Port: in_data  in  32  IEEE-754 single-precision element.
REQ-010 Port: in_ready  out  1  block accepts in_data this cycle.
REQ-011 Port: busy  out  1  high in every state except IDLE.
REQ-012 Port: done  out  1  one-cycle pulse at scan completion.
REQ-013 Port: err_empty  out  1  last scan had len==0; valid while done is high and held until the next start.
REQ-014 Port: min_val / max_val  out  32  running and final minimum and maximum.
REQ-015 Port: min_idx / max_idx  out  IDX_W  zero-based positions of min_val and max_val.

Function
REQ-016 States SHALL be IDLE, WAIT_IN, CMP_MIN, CMP_MAX and DONE.
REQ-017 IDLE: start=1 with len==0 SHALL go to DONE with err_empty=1; start=1 with len>0 SHALL go to WAIT_IN with count=0.
REQ-018 len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 in_ready SHALL equal 1 only in WAIT_IN; a handshake is in_valid & in_ready.
REQ-021 A handshake SHALL capture in_data into hold_reg and increment count.
REQ-022 First element (count==0 at handshake) SHALL load min_val=max_val=in_data and min_idx=max_idx=0, then go to DONE if len==1, else stay in WAIT_IN.
REQ-023 Any later handshake SHALL go to CMP_MIN.
REQ-024 One shared single_less_than instance SHALL perform all compares; its operands SHALL be muxed by state.
REQ-025 CMP_MIN SHALL drive a=hold_reg and b=min_val; if the result is 1, it SHALL load min_val=hold_reg and min_idx=count-1; it SHALL then go to CMP_MAX.
REQ-026 CMP_MAX SHALL drive a=max_val and b=hold_reg; if the result is 1, it SHALL load max_val=hold_reg and max_idx=count-1; it SHALL go to DONE if count==len, else to WAIT_IN.
REQ-027 Updates SHALL occur only on strict less-than, so ties keep the earliest index.
REQ-028 The comparator's -0.0 < +0.0 ordering SHALL apply, and NaN SHALL receive no special handling.
REQ-029 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-030 Throughput SHALL be 1 cycle for the first element and 3 cycles per element after that (handshake, CMP_MIN, CMP_MAX).
REQ-031 Results SHALL hold from DONE until the next accepted start; a start with len>0 SHALL clear err_empty.

Reset
REQ-032 reset SHALL force IDLE, count=0, hold_reg=0, min_val=max_val=0, min_idx=max_idx=0, done=0, err_empty=0, in_ready=0 and busy=0, immediately and independent of clk.
REQ-033 Reset asserted mid-scan SHALL discard the scan with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-034 Macro SINGLE_MINMAX_ABORT_EN defined: the block SHALL add input port abort (1 bit).
REQ-035 With SINGLE_MINMAX_ABORT_EN, abort=1 while busy SHALL return to IDLE on the next edge with no done pulse; min/max outputs SHALL retain partial results; abort SHALL take priority over a same-cycle handshake.
REQ-036 Without SINGLE_MINMAX_ABORT_EN, there SHALL be no abort port and scans SHALL always run to DONE.

Verification
REQ-037 Stream len=4: 3F800000, C0000000, 40600000, 3F000000, in_valid held high -> done pulse with min_val=C0000000, min_idx=1, max_val=40600000, max_idx=2, err_empty=0, 11 cycles after start.
REQ-038 start with len=0 -> done one cycle later with err_empty=1, and in_ready never asserted.
REQ-039 Stream len=3: 3F800000, 3F800000, 3F800000 -> min_idx=0, max_idx=0 (tie keeps earliest).
REQ-040 Stream len=2: 00000000, 80000000 -> min_val=80000000, min_idx=1, max_val=00000000, max_idx=0.
REQ-041 reset asserted in CMP_MIN of a len=4 scan -> all outputs 0 immediately; no done pulse; a new start with len=1 and data 40000000 -> min=max=40000000.
REQ-042 With SINGLE_MINMAX_ABORT_EN: abort after 2 elements 3F800000, C0000000 of a len=4 scan -> IDLE, no done, min_val=C0000000, max_val=3F800000; start ignored while busy.
